// File: rtl/ram_burst_pkg.sv
// rtl/ram_burst_pkg.sv - shared types and constants for the RAM burst controller
// Contents: controller state enum, RAM address/line widths, response FIFO depth.
package ram_burst_pkg;

  localparam int ADDR_W     = 14;
  localparam int LINE_W     = 8;
  localparam int RESP_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rd_resp_fifo.sv
// rtl/rd_resp_fifo.sv - 2-entry synchronous FIFO holding {last, data} read responses
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   write one entry; accepted when not full, or full with a pop
//   pop,  pop_data    remove head entry; pop_data shows the head combinationally
//   full, empty       occupancy flags
//   count             number of stored entries (0..RESP_DEPTH)
module rd_resp_fifo
  import ram_burst_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [RESP_DEPTH];
  logic [W-1:0] mem_d [RESP_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q,  count_d;
  logic         do_push, do_pop;

  assign full     = (count_q == 2'(RESP_DEPTH));
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A pop frees the head slot in the same cycle, so a full FIFO may still push.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst read/write sequencer in front of a 256-line register RAM
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_len                   burst command (req_len+1 words at req_addr[7:0])
//   wdata_valid/wdata_ready/wdata      write word stream (WRITE state only)
//   rdata_valid/rdata_ready/
//   rdata/rdata_last                   read response stream out of the response FIFO
//   ram_addr/ram_d/ram_WrEn/ram_q      RAM port; ram_q is registered inside the RAM
//   busy                               burst in progress or responses still buffered
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [SIZE-1:0]   wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [SIZE-1:0]   rdata,
  output logic              rdata_last,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [SIZE-1:0]   ram_d,
  output logic              ram_WrEn,
  input  logic [SIZE-1:0]   ram_q,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic                last_pend_q, last_pend_d;

  logic [LINE_W-1:0]   line_addr;
  logic                ram_we_c;
  logic                issue;
  logic                credit;
  logic [2:0]          occ;

  logic                fifo_pop;
  logic                fifo_empty;
  logic [1:0]          fifo_count;
  logic [SIZE:0]       fifo_head;
  logic                unused_fifo_full;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:LINE_W];

  // 8-bit line arithmetic wraps 255 -> 0.
  assign line_addr = base_q + LINE_W'(cnt_q);
  assign fifo_pop  = rdata_ready && !fifo_empty;

  // Outstanding responses = buffered + one in flight from the RAM. A pop in
  // this cycle frees a slot, which keeps reads streaming at one word per cycle.
  assign occ    = 3'(fifo_count) + 3'(inflight_q);
  assign credit = occ < (3'(RESP_DEPTH) + 3'(fifo_pop));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_we_c    = 1'b0;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          base_d  = req_addr[LINE_W-1:0];
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          ram_we_c = 1'b1;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) state_d = IDLE;
        end
      end
      READ: begin
        if (credit) begin
          issue = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    inflight_d  = issue;
    last_pend_d = issue && (cnt_q == len_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      last_pend_q <= last_pend_d;
    end
  end

  // The RAM shares this reset; keep its write enable off while reset is held.
  assign ram_WrEn = ram_we_c && rst_n;
  assign ram_addr = {{(ADDR_W-LINE_W){1'b0}}, line_addr};
  assign ram_d    = ram_we_c ? wdata : '0;

  rd_resp_fifo #(
    .W (SIZE + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({last_pend_q, ram_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rdata_valid = !fifo_empty;
  assign rdata       = fifo_empty ? '0 : fifo_head[SIZE-1:0];
  assign rdata_last  = !fifo_empty && fifo_head[SIZE];
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller sitting directly upstream of the 256-line register RAM block. Accepts burst read/write commands over valid/ready and sequences one word per cycle onto the RAM's addr/d/WrEn port. Captures the RAM's registered q output into a 2-entry response FIFO so read data tolerates consumer backpressure. Serves as the single master of one RAM instance.

## Interface
- SIZE, 32, data word width; matches the RAM instance.
- LEN_W, 4, burst length field width; a burst is req_len+1 words, 1..16.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when both high; high only in IDLE.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  14  base line address; only bits [7:0] used.
- req_len  in  LEN_W  words minus one.
- wdata_valid  in  1  write word valid.
- wdata_ready  out  1  high in WRITE state.
- wdata  in  SIZE  write word.
- rdata_valid  out  1  response word valid (FIFO not empty).
- rdata_ready  in  1  consumer takes word when both high.
- rdata  out  SIZE  response word.
- rdata_last  out  1  marks final word of a read burst.
- ram_addr  out  14  to RAM addr; bits [13:8] always 0.
- ram_d  out  SIZE  to RAM d.
- ram_WrEn  out  1  to RAM WrEn.
- ram_q  in  SIZE  from RAM q; registered by RAM, valid the cycle after a read issue.
- busy  out  1  state != IDLE or FIFO non-empty.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: req_ready=1; on handshake latch we, base[7:0], len; word counter cnt=0; go to WRITE or READ.
- WRITE: wdata_ready=1; each wdata handshake drives ram_WrEn=1, ram_d=wdata, ram_addr={6'b0, base+cnt mod 256}, cnt++. After word len: go to IDLE. No handshake means ram_WrEn=0.
- READ: a read is issued (ram_WrEn=0, ram_addr as above) when FIFO count + in-flight < 2; in-flight is a 1-bit flag set on issue and cleared next cycle. Issue of word len goes to DRAIN.
- In the cycle after an issue, ram_q is pushed into the FIFO with last = (issued cnt == len).
- DRAIN: no issues; go to IDLE when in-flight=0. The FIFO may still hold words; busy stays high until it empties.
- Address arithmetic is 8-bit, wrapping 255 to 0. req_addr[13:8] is ignored.
- Out-of-state inputs are ignored: wdata outside WRITE, req_valid outside IDLE.
- Simultaneous FIFO push and pop is allowed at any count, including full with a pop.

## Timing
- Reset (rst_n=0 at an edge) sets: state IDLE, cnt 0, in-flight 0, FIFO empty. All outputs 0 except req_ready, which is 1 after reset releases.
- ram_WrEn must be 0 during reset. The RAM clears its contents on the same reset.
- Reset mid-burst aborts the burst; pending FIFO words are discarded.
- Write word latency: the word is in RAM at the edge ending its handshake cycle.
- Read latency: command accepted at edge 0. First issue in cycle 1, ram_q valid in cycle 2, rdata_valid in cycle 3.
- With rdata_ready held high, one word per cycle thereafter.
- Minimum one IDLE cycle between bursts.

## Structure
- Package ram_burst_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - constants ADDR_W=14, LINE_W=8, RESP_DEPTH=2.
- Sub-module rd_resp_fifo: 2-entry synchronous FIFO of {last, data}, with push/pop/full/empty/count and the same clk/rst_n.

## Test plan
- Write len=0 at addr 5 data 0xA5A5_0001, then read len=0 at addr 5: rdata=0xA5A5_0001 and rdata_last=1 in cycle 3 after read accept. ram_WrEn high exactly one cycle.
- Write burst len=15 at addr 250, data 0..15, then read back: ram_addr sequence 250..255,0..9; rdata 0..15; rdata_last only on the 16th word.
- Read burst len=7 with rdata_ready low for 10 cycles: at most 2 words buffered, no issues while full. After release, all 8 words arrive in order with none lost or duplicated.
- Write burst with wdata_valid toggling every other cycle: ram_WrEn only on handshake cycles. Burst completes after 4 handshakes for len=3.
- rst_n low for one cycle mid read burst: next cycle state IDLE, rdata_valid=0, busy=0. Reading a previously written line returns 0.
- req_valid held high throughout a burst: req_ready=0 until IDLE. The second command is accepted exactly once.
